im_fetch_ctrl: RTL
==================

# im_fetch_ctrl

Instruction-fetch sequencer for the MIPS-lite datapath. It owns the program counter, drives the word address of the combinational instruction memory `im`, and registers each fetched word into a one-entry output buffer. Decode consumes that buffer through a valid/ready handshake. Branch/jump redirects and a halt request from the control unit steer the sequencer.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width (matches `im` address port)
- `RESET_PC`, 8'h00: PC value loaded on reset
- `clk`  in  1: system clock, rising-edge
- `reset`  in  1: asynchronous, active-high reset
- `im_addr`  out  ADDR_W: address to `im`, equal to current PC register
- `im_data`  in  32: instruction word from `im`, same-cycle combinational
- `if_valid`  out  1: output buffer holds an instruction
- `if_instr`  out  32: buffered instruction
- `if_pc`  out  ADDR_W: address the buffered instruction was fetched from
- `if_ready`  in  1: decode accepts buffer this cycle
- `redirect`  in  1: branch/jump taken, one-cycle pulse
- `redirect_pc`  in  ADDR_W: target address, sampled when `redirect`=1
- `halt_req`  in  1: stop fetching
- `halted`  out  1: sequencer in HALT state
- `fetch_count`  out  16: accepted handshakes, saturating

## Operation
- States: FETCH, HALT. Reset -> FETCH.
- Reset values: pc=RESET_PC, `if_valid`=0, `if_instr`=32'h0, `if_pc`=0, `halted`=0, `fetch_count`=0.
- `im_addr` = pc, combinational from the register.
- Handshake: transfer when `if_valid`&&`if_ready`. `if_instr`/`if_pc` hold stable while `if_valid`=1 and `if_ready`=0.
- Load condition in FETCH, no redirect: buffer empty or transfer this cycle. On load: `if_instr`<=`im_data`, `if_pc`<=pc, `if_valid`<=1, pc<=pc+1. Otherwise pc holds.
- Load with no transfer while full: pc holds, no load (stall).
- PC arithmetic: modulo 2^ADDR_W. 8'hFF+1 -> 8'h00, with no flag.
- Redirect, any state: pc<=`redirect_pc` and `if_valid`<=0 (flush). No load that cycle; redirect has priority over load.
- FETCH -> HALT on `halt_req`=1. No new load that cycle or after. A buffered instruction stays valid until transferred; then `if_valid`<=0.
- HALT -> FETCH on `redirect`=1 with `halt_req`=0. pc<=`redirect_pc`, and fetch resumes next cycle.
- `halt_req` and `redirect` together: redirect applied (pc update, flush), next state HALT.
- `halted` = (state==HALT), registered.
- `fetch_count` increments on every transfer, including a transfer in a redirect cycle (the instruction was accepted before flush). Saturates at 16'hFFFF.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and any in-flight instruction is dropped.

## Timing
- First edge after reset release: buffer loads `im[RESET_PC]`, `if_valid`=1, pc=RESET_PC+1.
- Throughput: one instruction per cycle while `if_ready`=1 and no redirect.
- Redirect latency: redirect at edge N -> `if_valid`=0 after N. `im[redirect_pc]` is in the buffer after edge N+1. This is a one-bubble penalty.
- Halt: `halted`=1 after the edge sampling `halt_req`.
- No combinational path from `if_ready`, `redirect` or `halt_req` to any output; all outputs are registered except `im_addr`, which comes from the pc register.

## Test plan
- Reset, `if_ready`=1, `im` word n = 32'h1000_0000+n: `if_pc` 00,01,02… on consecutive cycles, `if_instr` matches, `fetch_count`=3 after 3 transfers.
- Backpressure: hold `if_ready`=0 for 4 cycles at pc 0x02 -> `if_instr`/`if_pc`=0x01 stable, `im_addr`=0x02 constant. Release -> stream continues 0x02,0x03 with no loss or duplication.
- Redirect to 0x40 while buffer holds 0x05 with `if_ready`=1 -> 0x05 counted, one bubble, next `if_pc`=0x40, then 0x41.
- Wrap: redirect to 0xFE -> `if_pc` sequence 0xFE, 0xFF, 0x00.
- Halt with `if_ready`=0 and buffer holding 0x07 -> `halted`=1, 0x07 held. `if_ready`=1 -> 0x07 transferred, then `if_valid`=0 forever. Redirect 0x10 -> FETCH, `if_pc`=0x10.
- Assert `reset` asynchronously mid-stream at pc 0x33 -> outputs zero immediately, `im_addr`=RESET_PC. After release, the first `if_pc`=0x00.

Source files
------------

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational instruction
// memory and hands fetched words to decode through a one-entry valid/ready buffer.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | PC advances and the buffer refills whenever it empties or drains
// HALT  | no new fetches; a buffered word may still drain; redirect resumes
module im_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_data,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic              xfer;
    logic              load;

    assign im_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect always lands in the state requested by halt_req, from either state.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = halt_req ? HALT : FETCH;
        end else if (state_q == FETCH && halt_req) begin
            state_d = HALT;
        end
    end

    always_comb begin
        xfer   = if_valid && if_ready;
        load   = (state_q == FETCH) && !redirect && !halt_req && (!if_valid || xfer);
        halted = (state_q == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0;
            if_pc       <= '0;
            fetch_count <= 16'h0;
        end else begin
            if (redirect) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
            end else if (load) begin
                if_instr <= im_data;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + 1'b1;
            end else if (xfer) begin
                if_valid <= 1'b0;
            end
            // A word accepted in the same cycle as a flush still counts.
            if (xfer && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule
